spi_slave_core: RTL and testbench
=================================

# spi_slave_core

Byte-oriented SPI slave engine that consumes the slave side of `spi_if` and converts serial frames into parallel words for the on-chip register/bus logic. All SPI pins are oversampled in the single system clock domain; no logic runs on `sclk`. Supports SPI mode 0 only (CPOL=0, CPHA=0), MSB first. Provides valid/ready handshakes on both receive and transmit word streams.

## Interface
- `DATA_WIDTH`, 8: bits per SPI word.
- `TX_IDLE`, 8'hFF: word shifted out when no transmit data is available (width DATA_WIDTH).
- `clk`  input  1  system clock; must be ≥ 4× the `sclk` frequency.
- `rst_n`  input  1  asynchronous, active-low reset.
- `spi`  modport  `spi_if.slave`  `sclk`, `nss`, `mosi` inputs; `miso` output.
- `rx_data`  output  DATA_WIDTH  last received word; reset 0.
- `rx_valid`  output  1  `rx_data` holds an unconsumed word; reset 0.
- `rx_ready`  input  1  consumer accepts `rx_data` when `rx_valid & rx_ready`.
- `tx_data`  input  DATA_WIDTH  next word to transmit.
- `tx_valid`  input  1  `tx_data` available.
- `tx_ready`  output  1  one-cycle pulse: `tx_data` taken into shifter; reset 0.
- `busy`  output  1  frame active (synchronised `nss` low); reset 0.
- `rx_overrun`  output  1  one-cycle pulse: word completed while `rx_valid` still high; reset 0.
- `tx_underrun`  output  1  one-cycle pulse: TX_IDLE loaded because `tx_valid` was low; reset 0.

## Operation
- Each of `sclk`, `nss`, `mosi` passes through a 2-flop synchroniser; `sclk` and `nss` additionally go through a rise/fall edge detector.
- States: IDLE, ACTIVE.
  - IDLE → ACTIVE on synchronised `nss` falling edge: bit counter := 0, load TX word, `busy` := 1.
  - ACTIVE → IDLE on synchronised `nss` rising edge: partial RX word discarded, bit counter := 0, `busy` := 0; no `rx_valid`, no `tx_ready`.
- TX word load (at frame start and at each word boundary): if `tx_valid`, load `tx_data` and pulse `tx_ready`; else load TX_IDLE and pulse `tx_underrun`.
- RX: on each `sclk` rise in ACTIVE, shift synchronised `mosi` into the LSB of the RX shifter; increment bit counter (0..DATA_WIDTH-1, wraps to 0).
- On the DATA_WIDTH-th rise: if `rx_valid` is 0 or is being consumed that same cycle, `rx_data` := completed word and `rx_valid` := 1; otherwise keep the old `rx_data` and pulse `rx_overrun`.
- `rx_valid` clears on `rx_valid & rx_ready` unless a new word is written in the same cycle (the new word wins and `rx_valid` stays 1).
- MISO: driven from the TX shifter MSB while ACTIVE; high-impedance in IDLE and during reset. Shift left on each `sclk` fall. The fall following the DATA_WIDTH-th rise loads the next word instead of shifting.
- `sclk` edges in IDLE are ignored.

## Timing
- Let N be the first `clk` edge at which `sclk` is sampled high. The edge pulse occurs at N+2, and the shifter/`rx_data`/`rx_valid` update at N+3.
- `miso` updates at clk edge M+3, where M is the first `clk` edge sampling `sclk` low (or, at frame start, `nss` low).
- Master requirement: ≥ 4 `clk` periods between `nss` fall and the first `sclk` rise; `sclk` high and low phases each ≥ 2 `clk` periods.
- `tx_ready`, `rx_overrun`, `tx_underrun` are exactly one `clk` wide.
- Reset is asynchronous assert and synchronous deassert (handled outside the block). Reset mid-frame returns to IDLE immediately, with all outputs at their reset values.

## Structure
- `spi_slave_pkg` holds the state enum (`SPI_IDLE`, `SPI_ACTIVE`) and the default TX_IDLE constant.
- Sub-module `spi_sync_edge`: 2-flop synchroniser plus optional rise/fall pulse outputs. Instantiated three times (`sclk`, `nss`, `mosi`; edge outputs unused for `mosi`).
- FSM, bit counter and shifters stay in `spi_slave_core`.

## Test plan
- Single frame, MOSI 8'hA5, `tx_data`=8'h3C with `tx_valid` held → `rx_data`=8'hA5 with `rx_valid`; MISO bits 0,0,1,1,1,1,0,0; one `tx_ready` pulse at `nss` fall.
- Two-word frame 8'h12, 8'h34, `rx_ready` always high → two `rx_valid` words in order; second TX word is loaded on the 8th `sclk` fall.
- `rx_ready` held low across two words → first word 8'h12 retained, one `rx_overrun` pulse at completion of the second word.
- `tx_valid` low at frame start → MISO shifts 8'hFF, one `tx_underrun` pulse.
- `nss` raised after 5 bits → no `rx_valid`; `busy` falls; the next full frame receives its word correctly.
- `rst_n` asserted mid-word → all outputs at reset values and `miso` high-Z within the same cycle; the next frame starts cleanly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave engine.
package spi_slave_pkg;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [7:0] SPI_TX_IDLE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_if.sv
// SPI pin bundle: the master drives sclk/nss/mosi, and the slave drives miso.
interface spi_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;

  modport master (output sclk, output nss, output mosi, input miso);
  modport slave  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;
  logic rise_q, fall_q;

  // Synchronise the input, keep one delayed copy, and register the edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= RST_VAL;
      s2     <= RST_VAL;
      s3     <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= d;
      s2     <= s1;
      s3     <= s2;
      rise_q <= s2 & ~s3;
      fall_q <= ~s2 & s3;
    end
  end

  assign level = s2;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave, MSB first, oversampled in the clk domain, with word handshakes.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  TX_IDLE    = SPI_TX_IDLE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_if.slave                  spi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  rx_overrun,
  output logic                  tx_underrun
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  spi_state_e            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic                  load_pend;

  logic sclk_rise, sclk_fall, nss_rise, nss_fall, mosi_s;
  logic sclk_lvl_unused, nss_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] tx_word;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.sclk),
    .level (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_nss (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.nss),
    .level (nss_lvl_unused),
    .rise  (nss_rise),
    .fall  (nss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // Build the completed RX word and select the next TX word.
  always_comb begin
    rx_word = {rx_sh[DATA_WIDTH-2:0], mosi_s};
    tx_word = tx_valid ? tx_data : TX_IDLE;
  end

  // Frame FSM, bit counter, shifters, and handshake/status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SPI_IDLE;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      load_pend   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_ready    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      // A word completed later in this block overrides this clear.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        SPI_IDLE: begin
          if (nss_fall) begin
            state       <= SPI_ACTIVE;
            busy        <= 1'b1;
            bit_cnt     <= '0;
            load_pend   <= 1'b0;
            tx_sh       <= tx_word;
            tx_ready    <= tx_valid;
            tx_underrun <= ~tx_valid;
          end
        end
        SPI_ACTIVE: begin
          if (nss_rise) begin
            state     <= SPI_IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            load_pend <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_sh <= rx_word;
              if (bit_cnt == CNT_LAST) begin
                bit_cnt   <= '0;
                load_pend <= 1'b1;
                if (!rx_valid || rx_ready) begin
                  rx_data  <= rx_word;
                  rx_valid <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (sclk_fall) begin
              if (load_pend) begin
                load_pend   <= 1'b0;
                tx_sh       <= tx_word;
                tx_ready    <= tx_valid;
                tx_underrun <= ~tx_valid;
              end else begin
                tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

  assign spi.miso = (state == SPI_ACTIVE) ? tx_sh[DATA_WIDTH-1] : 1'bz;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: frames, handshakes, abort and reset.
module tb_spi_slave_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_if bus();

  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, busy, rx_overrun, tx_underrun;

  spi_slave_core #(.DATA_WIDTH(8), .TX_IDLE(8'hFF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (bus.slave),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int n_txr = 0, n_ovr = 0, n_und = 0, n_wide = 0, n_rx = 0;
  logic [7:0] rx_log [16];
  logic p_txr = 1'b0, p_ovr = 1'b0, p_und = 1'b0;

  // Pulse counters, pulse-width watch, and a log of consumed RX words.
  always @(negedge clk) begin
    if (tx_ready)    n_txr++;
    if (rx_overrun)  n_ovr++;
    if (tx_underrun) n_und++;
    if ((tx_ready && p_txr) || (rx_overrun && p_ovr) || (tx_underrun && p_und)) n_wide++;
    p_txr = tx_ready;
    p_ovr = rx_overrun;
    p_und = tx_underrun;
    if (rx_valid && rx_ready && n_rx < 16) begin
      rx_log[n_rx] = rx_data;
      n_rx++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    bus.nss = 1'b0;
    clks(6);
  endtask

  task automatic frame_end();
    clks(2);
    bus.nss = 1'b1;
    clks(6);
  endtask

  // Mode-0 master: present MOSI while sclk is low, sample MISO just before the rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      clks(5);
      mi[7-i] = bus.miso;
      bus.sclk = 1'b1;
      clks(4);
      bus.sclk = 1'b0;
    end
    clks(5);
  endtask

  logic [7:0] mi;
  int b_txr, b_ovr, b_und, b_rx;

  initial begin
    rst_n    = 1'b0;
    bus.sclk = 1'b0;
    bus.nss  = 1'b1;
    bus.mosi = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #1;
    chk("reset_outputs", {19'd0, rx_data, rx_valid, tx_ready, busy, rx_overrun, tx_underrun}, 32'h0);
    clks(3);
    rst_n = 1'b1;
    clks(5);

    // Single frame: MOSI A5, TX 3C
    tx_data = 8'h3C; tx_valid = 1'b1;
    b_txr = n_txr;
    frame_start();
    chk("t1_busy", busy, 1);
    chk("t1_txr_at_start", n_txr - b_txr, 1);
    xfer(8'hA5, 8, mi);
    chk("t1_miso", mi, 8'h3C);
    frame_end();
    chk("t1_busy_low", busy, 0);
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_txr_total", n_txr - b_txr, 2);
    rx_ready = 1'b1; clks(1); rx_ready = 1'b0; clks(2);
    chk("t1_rx_consumed", rx_valid, 0);

    // Two-word frame with rx_ready held high
    rx_ready = 1'b1; tx_data = 8'h55;
    b_rx = n_rx; b_txr = n_txr;
    frame_start();
    tx_data = 8'hC3;
    xfer(8'h12, 8, mi);
    chk("t2_miso_w0", mi, 8'h55);
    chk("t2_txr_after_8th_fall", n_txr - b_txr, 2);
    xfer(8'h34, 8, mi);
    chk("t2_miso_w1", mi, 8'hC3);
    frame_end();
    chk("t2_rx_count", n_rx - b_rx, 2);
    chk("t2_rx_w0", rx_log[b_rx], 8'h12);
    chk("t2_rx_w1", rx_log[b_rx+1], 8'h34);
    rx_ready = 1'b0;
    clks(2);

    // Overrun: rx_ready low across two words
    b_ovr = n_ovr;
    frame_start();
    xfer(8'h12, 8, mi);
    chk("t3_rx_valid_w0", rx_valid, 1);
    chk("t3_ovr_none_yet", n_ovr - b_ovr, 0);
    xfer(8'h34, 8, mi);
    frame_end();
    chk("t3_rx_retained", rx_data, 8'h12);
    chk("t3_ovr_one", n_ovr - b_ovr, 1);
    rx_ready = 1'b1; clks(1); rx_ready = 1'b0; clks(2);

    // Underrun: tx_valid low at frame start
    tx_valid = 1'b0;
    b_und = n_und;
    frame_start();
    chk("t4_und_at_start", n_und - b_und, 1);
    xfer(8'h00, 8, mi);
    chk("t4_miso_idle", mi, 8'hFF);
    frame_end();
    rx_ready = 1'b1; clks(1); rx_ready = 1'b0; clks(2);

    // Abort after 5 bits, then a full frame
    tx_valid = 1'b1; tx_data = 8'hAA;
    frame_start();
    xfer(8'hF0, 5, mi);
    bus.nss = 1'b1;
    clks(6);
    chk("t5_busy_low", busy, 0);
    chk("t5_no_rx_valid", rx_valid, 0);
    frame_start();
    xfer(8'h5A, 8, mi);
    chk("t5_miso_next", mi, 8'hAA);
    frame_end();
    chk("t5_rx_valid", rx_valid, 1);
    chk("t5_rx_data", rx_data, 8'h5A);

    // Reset asserted mid-word with rx_valid still set
    frame_start();
    xfer(8'hC5, 3, mi);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {19'd0, rx_data, rx_valid, tx_ready, busy, rx_overrun, tx_underrun}, 32'h0);
    bus.nss = 1'b1; bus.sclk = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(5);
    tx_data = 8'h96;
    frame_start();
    xfer(8'hE7, 8, mi);
    chk("t6_miso_after_reset", mi, 8'h96);
    frame_end();
    chk("t6_rx_valid", rx_valid, 1);
    chk("t6_rx_data", rx_data, 8'hE7);

    chk("pulse_widths", n_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
